// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter in front of a single APB master.
// NREQ local requesters each post one read or write. The winner's payload is
// latched at grant and driven through the APB SETUP/ACCESS phases. The
// result is returned with a one-cycle done pulse on the winner's bit.
module apb_master_arb #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          done,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AWIDTH-1:0]        PADDR,
  output logic [DWIDTH-1:0]        PWDATA,
  input  logic [DWIDTH-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  // Index width for requester numbers, counter width for the ACCESS timeout.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(NREQ - 1);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam bit            TO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t              r_state;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [AWIDTH-1:0]   r_paddr;
  logic [DWIDTH-1:0]   r_pwdata;
  logic [NREQ-1:0]     r_done;
  logic [DWIDTH-1:0]   r_rdata;
  logic                r_err;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_winner;
  logic [CW-1:0]       r_cnt;

  logic [AWIDTH-1:0]   w_addr_arr  [NREQ];
  logic [DWIDTH-1:0]   w_wdata_arr [NREQ];
  logic [IW-1:0]       w_ptr;
  logic [NREQ-1:0]     w_mask;
  logic [NREQ-1:0]     w_req_eff;
  logic                w_win_valid;
  logic [IW-1:0]       w_win_idx;
  logic                w_timeout;
  logic                w_complete;

  // Split the packed per-requester payload buses into indexable arrays.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = req_addr[gi*AWIDTH +: AWIDTH];
      assign w_wdata_arr[gi] = req_wdata[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  // On the completion edge the finishing requester may still hold req high,
  // so it is masked and the search starts just after it (it becomes the new
  // last winner on that same edge). Otherwise search after the last winner.
  always_comb begin
    w_mask = '0;
    w_ptr  = r_last;
    if (r_state == S_ACCESS) begin
      w_mask[r_winner] = 1'b1;
      w_ptr            = r_winner;
    end
    w_req_eff = req & ~w_mask;
  end

  // Round-robin search: first eligible request upward from w_ptr+1, wrapping.
  always_comb begin : p_scan
    logic [IW-1:0] v_scan;
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    v_scan      = w_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (v_scan == IDX_MAX) begin
        v_scan = '0;
      end else begin
        v_scan = v_scan + IW'(1);
      end
      if (!w_win_valid && w_req_eff[v_scan]) begin
        w_win_valid = 1'b1;
        w_win_idx   = v_scan;
      end
    end
  end

  // An ACCESS cycle ends the transfer on PREADY, or on the timeout cycle.
  always_comb begin
    w_timeout  = TO_EN && (r_cnt == TO_VAL);
    w_complete = (r_state == S_ACCESS) && (PREADY || w_timeout);
  end

  // Sequencer: arbitration, APB phases, completion and response capture.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_last    <= IDX_MAX;
      r_winner  <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_win_valid) begin
            r_pwrite  <= req_write[w_win_idx];
            r_paddr   <= w_addr_arr[w_win_idx];
            r_pwdata  <= w_wdata_arr[w_win_idx];
            r_winner  <= w_win_idx;
            r_cnt     <= '0;
            r_psel    <= 1'b1;
            r_state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_psel    <= 1'b1;
          r_penable <= 1'b1;
          r_cnt     <= CW'(1);
          r_state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (w_complete) begin
            // w_mask is the one-hot of the current winner while in ACCESS.
            r_done <= w_mask;
            r_last <= r_winner;
            if (PREADY) begin
              r_err   <= PSLVERR;
              r_rdata <= r_pwrite ? '0 : PRDATA;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
            r_penable <= 1'b0;
            if (w_win_valid) begin
              // Back-to-back: stay selected and go straight to SETUP.
              r_pwrite <= req_write[w_win_idx];
              r_paddr  <= w_addr_arr[w_win_idx];
              r_pwdata <= w_wdata_arr[w_win_idx];
              r_winner <= w_win_idx;
              r_cnt    <= '0;
              r_psel   <= 1'b1;
              r_state  <= S_SETUP;
            end else begin
              r_psel  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            // Saturate so a disabled timeout cannot wrap into a false match.
            if (r_cnt != TO_VAL) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign done      = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with hand-computed expectations.
module tb_apb_master_arb;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 2;
  localparam int TO = 15;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_write = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              PSLVERR = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_arb #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .NREQ   (NR),
    .TIMEOUT(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .done     (done),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Run one transfer for the already-posted request. PREADY is raised in the
  // ready_at-th ACCESS cycle (0 = never). Address is checked every ACCESS cycle.
  task automatic do_txn(input string tag, input int ready_at, input logic [AW-1:0] exp_addr,
                        output int pen, output logic [NR-1:0] dv,
                        output logic [DW-1:0] rd, output logic er);
    int bad;
    pen = 0; dv = '0; rd = '0; er = 1'b0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (PENABLE) begin
        pen++;
        if (PADDR !== exp_addr) bad++;
        if (pen == ready_at) PREADY = 1'b1;
      end
      if (done != '0) begin
        dv = done;
        rd = rsp_rdata;
        er = rsp_err;
        break;
      end
    end
    PREADY = 1'b0;
    check({tag, "_addr_stable"}, bad, 0);
    $display("txn %s: done=%b rdata=%h err=%b access_cycles=%0d", tag, dv, rd, er, pen);
  endtask

  initial begin
    int pen;
    logic [NR-1:0] dv;
    logic [DW-1:0] rd;
    logic er;
    int ndone;
    logic multi;
    logic drained;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    PRESET = 1'b0;
    tick();

    // Single write, PREADY tied high
    PREADY = 1'b1;
    req_write = 2'b01;
    req_addr  = {4'h0, 4'h2};
    req_wdata = {8'h00, 8'hA5};
    req = 2'b01;
    tick();
    check("wr_setup_psel", PSEL, 1);
    check("wr_setup_penable", PENABLE, 0);
    check("wr_setup_pwrite", PWRITE, 1);
    check("wr_setup_paddr", PADDR, 4'h2);
    check("wr_setup_pwdata", PWDATA, 8'hA5);
    tick();
    check("wr_access_penable", PENABLE, 1);
    check("wr_access_done", done, 0);
    tick();
    check("wr_done", done, 2'b01);
    check("wr_err", rsp_err, 0);
    check("wr_psel_low", PSEL, 0);
    $display("txn single_write: done=%b err=%b", done, rsp_err);
    req = 2'b00;
    PREADY = 1'b0;
    tick();
    check("wr_done_pulse", done, 0);

    // Read with wait states on requester 1
    req_write = 2'b00;
    req_addr  = {4'h6, 4'h0};
    PRDATA    = 8'h3C;
    req = 2'b10;
    do_txn("rd_wait", 3, 4'h6, pen, dv, rd, er);
    req = 2'b00;
    check("rd_wait_cycles", pen, 3);
    check("rd_wait_done", dv, 2'b10);
    check("rd_wait_rdata", rd, 8'h3C);
    check("rd_wait_err", er, 0);

    // Contention: both held, expect 0,1,0,1 with back-to-back SETUP
    req_write = 2'b11;
    req_addr  = {4'h9, 4'h3};
    req_wdata = {8'h22, 8'h11};
    PREADY = 1'b1;
    req = 2'b11;
    ndone = 0;
    multi = 1'b0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      tick();
      if ($countones(done) > 1) multi = 1'b1;
      if (done != '0) begin
        check("rr_order", done[1] ? 1 : 0, ndone % 2);
        check("rr_b2b_psel", PSEL, 1);
        check("rr_b2b_penable", PENABLE, 0);
        check("rr_b2b_paddr", PADDR, (ndone % 2 == 0) ? 4'h9 : 4'h3);
        $display("txn contention_%0d: done=%b next_paddr=%h", ndone, done, PADDR);
        ndone++;
      end
    end
    req = 2'b00;
    check("rr_count", ndone, 4);
    drained = 1'b0;
    for (int c = 0; c < 10 && !drained; c++) begin
      tick();
      if ($countones(done) > 1) multi = 1'b1;
      if (done != '0) drained = 1'b1;
    end
    check("rr_drain", drained, 1);
    check("rr_onehot", multi, 0);
    PREADY = 1'b0;
    tick();
    check("rr_idle_psel", PSEL, 0);

    // Slave error on read
    req_write = 2'b00;
    req_addr  = {4'h0, 4'hF};
    PRDATA    = 8'h5A;
    PSLVERR   = 1'b1;
    req = 2'b01;
    do_txn("slverr", 1, 4'hF, pen, dv, rd, er);
    req = 2'b00;
    PSLVERR = 1'b0;
    check("slverr_done", dv, 2'b01);
    check("slverr_err", er, 1);
    check("slverr_rdata", rd, 8'h5A);

    // Timeout with PREADY held low
    req_addr = {4'h0, 4'h1};
    PRDATA   = 8'hEE;
    req = 2'b01;
    do_txn("timeout", 0, 4'h1, pen, dv, rd, er);
    req = 2'b00;
    check("timeout_cycles", pen, 15);
    check("timeout_done", dv, 2'b01);
    check("timeout_err", er, 1);
    check("timeout_rdata", rd, 0);

    // PREADY exactly on the timeout cycle is a normal completion
    PRDATA = 8'h77;
    req = 2'b01;
    do_txn("ready_at_limit", 15, 4'h1, pen, dv, rd, er);
    req = 2'b00;
    check("limit_cycles", pen, 15);
    check("limit_done", dv, 2'b01);
    check("limit_err", er, 0);
    check("limit_rdata", rd, 8'h77);

    // Reset during the 2nd ACCESS cycle
    req_addr = {4'h6, 4'h1};
    req = 2'b01;
    tick();
    tick();
    tick();
    check("rst_mid_penable_pre", PENABLE, 1);
    #2;
    PRESET = 1'b1;
    #1;
    check("rst_mid_psel", PSEL, 0);
    check("rst_mid_penable", PENABLE, 0);
    check("rst_mid_done", done, 0);
    req = 2'b10;
    tick();
    check("rst_hold_done", done, 0);
    check("rst_hold_psel", PSEL, 0);
    #3;
    PRESET = 1'b0;
    PRDATA = 8'h42;
    do_txn("after_reset", 1, 4'h6, pen, dv, rd, er);
    req = 2'b00;
    check("after_rst_done", dv, 2'b10);
    check("after_rst_rdata", rd, 8'h42);
    check("after_rst_cycles", pen, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
